// File: rtl/alu_operand_sequencer.sv
// Operand sequencer in front of the ALU: fetches rs1/rs2 through one register-file
// read port, drives ALU microcode and operands, and hands the latched result to writeback.

package alu_operand_sequencer_pkg;
    typedef logic [3:0] alu_microcode_t;

    localparam alu_microcode_t ALU_MICROCODE_ADD  = 4'd0;
    localparam alu_microcode_t ALU_MICROCODE_SUB  = 4'd1;
    localparam alu_microcode_t ALU_MICROCODE_SLL  = 4'd2;
    localparam alu_microcode_t ALU_MICROCODE_SLT  = 4'd3;
    localparam alu_microcode_t ALU_MICROCODE_SLTU = 4'd4;
    localparam alu_microcode_t ALU_MICROCODE_XOR  = 4'd5;
    localparam alu_microcode_t ALU_MICROCODE_SRL  = 4'd6;
    localparam alu_microcode_t ALU_MICROCODE_SRA  = 4'd7;
    localparam alu_microcode_t ALU_MICROCODE_OR   = 4'd8;
    localparam alu_microcode_t ALU_MICROCODE_AND  = 4'd9;
    localparam alu_microcode_t ALU_MICROCODE_BEQ  = 4'd10;
    localparam alu_microcode_t ALU_MICROCODE_BNE  = 4'd11;
    localparam alu_microcode_t ALU_MICROCODE_BLT  = 4'd12;
    localparam alu_microcode_t ALU_MICROCODE_BGE  = 4'd13;
    localparam alu_microcode_t ALU_MICROCODE_BLTU = 4'd14;
    localparam alu_microcode_t ALU_MICROCODE_BGEU = 4'd15;
endpackage

module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int unsigned REG_ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     funct7_5,
    input  logic [REG_ADDR_BITS-1:0] rs1_addr,
    input  logic [REG_ADDR_BITS-1:0] rs2_addr,
    input  logic [31:0]              imm,
    output logic [REG_ADDR_BITS-1:0] rf_read_addr,
    input  logic [31:0]              rf_read_data,
    output alu_microcode_t           alu_microcode,
    output logic [31:0]              alu_in_a,
    output logic [31:0]              alu_in_b,
    input  logic [31:0]              alu_out,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [31:0]              result,
    output logic                     branch_taken,
    output logic                     illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_EXEC,
        S_DONE
    } state_t;

    // Returns {legal, microcode}; shared by the accept-time legality check and the latched decode.
    function automatic logic [4:0] decode(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        logic           legal;
        alu_microcode_t code;
        legal = 1'b1;
        code  = ALU_MICROCODE_ADD;
        case (op)
            OPC_OP, OPC_OPIMM: begin
                case (f3)
                    3'b000:  code = (op == OPC_OP && f75) ? ALU_MICROCODE_SUB : ALU_MICROCODE_ADD;
                    3'b001:  code = ALU_MICROCODE_SLL;
                    3'b010:  code = ALU_MICROCODE_SLT;
                    3'b011:  code = ALU_MICROCODE_SLTU;
                    3'b100:  code = ALU_MICROCODE_XOR;
                    3'b101:  code = f75 ? ALU_MICROCODE_SRA : ALU_MICROCODE_SRL;
                    3'b110:  code = ALU_MICROCODE_OR;
                    default: code = ALU_MICROCODE_AND;
                endcase
                if (op == OPC_OP && f75 && f3 != 3'b000 && f3 != 3'b101)
                    legal = 1'b0;
                if (op == OPC_OPIMM && f3 == 3'b001 && f75)
                    legal = 1'b0;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  code = ALU_MICROCODE_BEQ;
                    3'b001:  code = ALU_MICROCODE_BNE;
                    3'b100:  code = ALU_MICROCODE_BLT;
                    3'b101:  code = ALU_MICROCODE_BGE;
                    3'b110:  code = ALU_MICROCODE_BLTU;
                    3'b111:  code = ALU_MICROCODE_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        return {legal, code};
    endfunction

    state_t                   r_state;
    state_t                   w_state_next;
    logic [6:0]               r_opcode;
    logic [2:0]               r_funct3;
    logic                     r_funct7_5;
    logic [REG_ADDR_BITS-1:0] r_rs1;
    logic [REG_ADDR_BITS-1:0] r_rs2;
    logic [31:0]              r_a;
    logic [31:0]              r_b;
    logic [31:0]              r_result;
    logic                     r_branch_taken;
    logic                     r_illegal;
    logic [4:0]               w_in_dec;
    logic [4:0]               w_lat_dec;
    logic                     w_is_branch;

    assign w_in_dec      = decode(opcode, funct3, funct7_5);
    assign w_lat_dec     = decode(r_opcode, r_funct3, r_funct7_5);
    assign w_is_branch   = (r_opcode == OPC_BRANCH);

    assign alu_microcode = w_lat_dec[3:0];
    assign alu_in_a      = r_a;
    assign alu_in_b      = r_b;
    assign result        = r_result;
    assign branch_taken  = r_branch_taken;
    assign illegal       = r_illegal;
    assign result_valid  = (r_state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        start_ready  = 1'b0;
        rf_read_addr = '0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid)
                    w_state_next = w_in_dec[4] ? S_READ_A : S_DONE;
            end
            S_READ_A: begin
                rf_read_addr = r_rs1;
                w_state_next = (r_opcode == OPC_OPIMM) ? S_EXEC : S_READ_B;
            end
            S_READ_B: begin
                rf_read_addr = r_rs2;
                w_state_next = S_EXEC;
            end
            S_EXEC:  w_state_next = S_DONE;
            S_DONE:  if (result_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode       <= '0;
            r_funct3       <= '0;
            r_funct7_5     <= 1'b0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_branch_taken <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_opcode       <= opcode;
                        r_funct3       <= funct3;
                        r_funct7_5     <= funct7_5;
                        r_rs1          <= rs1_addr;
                        r_rs2          <= rs2_addr;
                        r_branch_taken <= 1'b0;
                        if (!w_in_dec[4]) begin
                            r_result  <= '0;
                            r_illegal <= 1'b1;
                        end else begin
                            r_illegal <= 1'b0;
                            // OP-IMM never visits READ_B, so the immediate is loaded into B here.
                            if (opcode == OPC_OPIMM)
                                r_b <= imm;
                        end
                    end
                end
                S_READ_A: r_a <= (r_rs1 == '0) ? '0 : rf_read_data;
                S_READ_B: r_b <= (r_rs2 == '0) ? '0 : rf_read_data;
                S_EXEC: begin
                    r_result       <= alu_out;
                    r_branch_taken <= alu_out[0] & w_is_branch;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural register file and ALU
// attached; expected values are hand-computed per step.

module tb_alu_operand_sequencer;
    import alu_operand_sequencer_pkg::*;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic           clk = 1'b0;
    logic           reset;
    logic           start_valid;
    logic           start_ready;
    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic           funct7_5;
    logic [4:0]     rs1_addr;
    logic [4:0]     rs2_addr;
    logic [31:0]    imm;
    logic [4:0]     rf_read_addr;
    logic [31:0]    rf_read_data;
    alu_microcode_t alu_microcode;
    logic [31:0]    alu_in_a;
    logic [31:0]    alu_in_b;
    logic [31:0]    alu_out;
    logic           result_valid;
    logic           result_ready;
    logic [31:0]    result;
    logic           branch_taken;
    logic           illegal;

    logic [31:0]    rf [32];
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.REG_ADDR_BITS(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .imm          (imm),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .alu_microcode(alu_microcode),
        .alu_in_a     (alu_in_a),
        .alu_in_b     (alu_in_b),
        .alu_out      (alu_out),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    assign rf_read_data = rf[rf_read_addr];

    always_comb begin
        alu_out = '0;
        case (alu_microcode)
            ALU_MICROCODE_ADD:  alu_out = alu_in_a + alu_in_b;
            ALU_MICROCODE_SUB:  alu_out = alu_in_a - alu_in_b;
            ALU_MICROCODE_SLL:  alu_out = alu_in_a << alu_in_b[4:0];
            ALU_MICROCODE_SLT:  alu_out = {31'd0, $signed(alu_in_a) < $signed(alu_in_b)};
            ALU_MICROCODE_SLTU: alu_out = {31'd0, alu_in_a < alu_in_b};
            ALU_MICROCODE_XOR:  alu_out = alu_in_a ^ alu_in_b;
            ALU_MICROCODE_SRL:  alu_out = alu_in_a >> alu_in_b[4:0];
            ALU_MICROCODE_SRA:  alu_out = $signed(alu_in_a) >>> alu_in_b[4:0];
            ALU_MICROCODE_OR:   alu_out = alu_in_a | alu_in_b;
            ALU_MICROCODE_AND:  alu_out = alu_in_a & alu_in_b;
            ALU_MICROCODE_BEQ:  alu_out = {31'd0, alu_in_a == alu_in_b};
            ALU_MICROCODE_BNE:  alu_out = {31'd0, alu_in_a != alu_in_b};
            ALU_MICROCODE_BLT:  alu_out = {31'd0, $signed(alu_in_a) < $signed(alu_in_b)};
            ALU_MICROCODE_BGE:  alu_out = {31'd0, $signed(alu_in_a) >= $signed(alu_in_b)};
            ALU_MICROCODE_BLTU: alu_out = {31'd0, alu_in_a < alu_in_b};
            default:            alu_out = {31'd0, alu_in_a >= alu_in_b};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single accept edge.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] im);
        opcode      = op;
        funct3      = f3;
        funct7_5    = f75;
        rs1_addr    = r1;
        rs2_addr    = r2;
        imm         = im;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'h0000_0010;
        rf[2] = 32'h0000_0018;
        rf[3] = 32'h0000_0005;
        rf[4] = 32'hFFFF_FFFF;
        rf[5] = 32'h0000_0001;
        rf[6] = 32'h8000_0000;

        reset        = 1'b1;
        start_valid  = 1'b0;
        result_ready = 1'b1;
        opcode       = '0;
        funct3       = '0;
        funct7_5     = 1'b0;
        rs1_addr     = '0;
        rs2_addr     = '0;
        imm          = '0;

        #3;
        chk("rst_start_ready",  start_ready,   1);
        chk("rst_result_valid", result_valid,  0);
        chk("rst_branch",       branch_taken,  0);
        chk("rst_illegal",      illegal,       0);
        chk("rst_micro",        alu_microcode, ALU_MICROCODE_ADD);
        chk("rst_rf_addr",      rf_read_addr,  0);
        chk("rst_result",       result,        0);
        chk("rst_a",            alu_in_a,      0);
        chk("rst_b",            alu_in_b,      0);
        tick();
        tick();
        reset = 1'b0;

        // ADDI x3 + (-1)
        issue(OPC_OPIMM, 3'b000, 1'b0, 5'd3, 5'd0, 32'hFFFF_FFFF);
        chk("addi_rf_addr_a", rf_read_addr,  3);
        chk("addi_micro",     alu_microcode, ALU_MICROCODE_ADD);
        chk("addi_b_imm",     alu_in_b,      32'hFFFF_FFFF);
        chk("addi_valid_c1",  result_valid,  0);
        chk("addi_ready_c1",  start_ready,   0);
        tick();
        chk("addi_a",         alu_in_a,      32'h0000_0005);
        chk("addi_valid_c2",  result_valid,  0);
        tick();
        chk("addi_valid_c3",  result_valid,  1);
        chk("addi_result",    result,        32'h0000_0004);
        chk("addi_branch",    branch_taken,  0);
        chk("addi_illegal",   illegal,       0);
        tick();
        chk("addi_valid_drop", result_valid, 0);
        chk("addi_ready_back", start_ready,  1);

        // SUB x1 - x2
        issue(OPC_OP, 3'b000, 1'b1, 5'd1, 5'd2, 32'h0);
        chk("sub_rf_addr_a", rf_read_addr,  1);
        chk("sub_micro",     alu_microcode, ALU_MICROCODE_SUB);
        tick();
        chk("sub_rf_addr_b", rf_read_addr,  2);
        chk("sub_a",         alu_in_a,      32'h0000_0010);
        chk("sub_valid_c2",  result_valid,  0);
        tick();
        chk("sub_b",         alu_in_b,      32'h0000_0018);
        chk("sub_valid_c3",  result_valid,  0);
        tick();
        chk("sub_valid_c4",  result_valid,  1);
        chk("sub_result",    result,        32'hFFFF_FFF8);
        tick();

        // BLTU -1 <u 1 : not taken
        issue(OPC_BRANCH, 3'b110, 1'b0, 5'd4, 5'd5, 32'h0);
        chk("bltu_micro", alu_microcode, ALU_MICROCODE_BLTU);
        tick();
        tick();
        tick();
        chk("bltu_valid",  result_valid, 1);
        chk("bltu_result", result,       0);
        chk("bltu_taken",  branch_taken, 0);
        tick();

        // BLT -1 <s 1 : taken
        issue(OPC_BRANCH, 3'b100, 1'b0, 5'd4, 5'd5, 32'h0);
        chk("blt_micro", alu_microcode, ALU_MICROCODE_BLT);
        tick();
        tick();
        tick();
        chk("blt_valid",  result_valid, 1);
        chk("blt_result", result,       1);
        chk("blt_taken",  branch_taken, 1);
        tick();
        chk("blt_valid_drop", result_valid, 0);

        // ORI from x0 while the register file returns garbage for address 0
        issue(OPC_OPIMM, 3'b110, 1'b0, 5'd0, 5'd0, 32'h0000_0005);
        chk("ori_rf_addr", rf_read_addr,  0);
        chk("ori_micro",   alu_microcode, ALU_MICROCODE_OR);
        tick();
        chk("ori_a_zero",  alu_in_a,      0);
        tick();
        chk("ori_result",  result,        32'h0000_0005);
        chk("ori_taken",   branch_taken,  0);
        tick();

        // SRAI by imm[4:0]=5, upper immediate bits kept on bus B
        issue(OPC_OPIMM, 3'b101, 1'b1, 5'd6, 5'd0, 32'h0000_0405);
        chk("srai_micro",  alu_microcode, ALU_MICROCODE_SRA);
        chk("srai_b",      alu_in_b,      32'h0000_0405);
        tick();
        tick();
        chk("srai_result", result,        32'hFC00_0000);
        tick();

        // Illegal: LOAD opcode
        issue(7'h03, 3'b010, 1'b0, 5'd3, 5'd4, 32'h0);
        chk("ill1_valid",   result_valid, 1);
        chk("ill1_flag",    illegal,      1);
        chk("ill1_result",  result,       0);
        chk("ill1_rf_addr", rf_read_addr, 0);
        tick();
        chk("ill1_idle",    start_ready,  1);

        // Illegal: OP funct3=001 with funct7_5=1
        issue(OPC_OP, 3'b001, 1'b1, 5'd3, 5'd4, 32'h0);
        chk("ill2_valid",   result_valid, 1);
        chk("ill2_flag",    illegal,      1);
        chk("ill2_result",  result,       0);
        tick();

        // Next legal op clears the illegal flag
        issue(OPC_OPIMM, 3'b000, 1'b0, 5'd3, 5'd0, 32'h0000_0001);
        chk("clr_illegal", illegal, 0);
        tick();
        tick();
        chk("clr_result",  result,  32'h0000_0006);
        tick();

        // Backpressure in DONE with start_valid held high
        result_ready = 1'b0;
        issue(OPC_OPIMM, 3'b000, 1'b0, 5'd3, 5'd0, 32'h0000_0002);
        tick();
        tick();
        opcode      = OPC_OP;
        funct3      = 3'b100;
        funct7_5    = 1'b0;
        rs1_addr    = 5'd1;
        rs2_addr    = 5'd2;
        start_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid",   result_valid,  1);
            chk("bp_result",  result,        32'h0000_0007);
            chk("bp_ready",   start_ready,   0);
            chk("bp_illegal", illegal,       0);
            chk("bp_micro",   alu_microcode, ALU_MICROCODE_ADD);
            tick();
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        tick();
        chk("bp_release_valid", result_valid, 0);
        chk("bp_release_ready", start_ready,  1);

        // Asynchronous reset while in READ_B
        issue(OPC_OP, 3'b000, 1'b1, 5'd1, 5'd2, 32'h0);
        tick();
        chk("ar_in_read_b", rf_read_addr, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_start_ready", start_ready,   1);
        chk("ar_valid",       result_valid,  0);
        chk("ar_rf_addr",     rf_read_addr,  0);
        chk("ar_micro",       alu_microcode, ALU_MICROCODE_ADD);
        chk("ar_a",           alu_in_a,      0);
        chk("ar_b",           alu_in_b,      0);
        chk("ar_result",      result,        0);
        chk("ar_illegal",     illegal,       0);
        chk("ar_branch",      branch_taken,  0);
        #1;
        reset = 1'b0;
        tick();
        chk("ar_stays_idle",  start_ready,   1);
        chk("ar_no_replay",   result_valid,  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
